// File: rtl/board_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment codes
// in {g,f,e,d,c,b,a} order, the all-off code and the slot FSM state type.
package board_pkg;

   // Slot phase: anodes held off for the first part of every slot, then driven.
   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   // Every cathode released (active low).
   localparam logic [6:0] SEG_OFF   = 7'h7F;

   // Hex glyphs, active low, bit 6 = g ... bit 0 = a.
   localparam logic [6:0] SEG_HEX_0 = 7'h40;
   localparam logic [6:0] SEG_HEX_1 = 7'h79;
   localparam logic [6:0] SEG_HEX_2 = 7'h24;
   localparam logic [6:0] SEG_HEX_3 = 7'h30;
   localparam logic [6:0] SEG_HEX_4 = 7'h19;
   localparam logic [6:0] SEG_HEX_5 = 7'h12;
   localparam logic [6:0] SEG_HEX_6 = 7'h02;
   localparam logic [6:0] SEG_HEX_7 = 7'h78;
   localparam logic [6:0] SEG_HEX_8 = 7'h00;
   localparam logic [6:0] SEG_HEX_9 = 7'h10;
   localparam logic [6:0] SEG_HEX_A = 7'h08;
   localparam logic [6:0] SEG_HEX_B = 7'h03;
   localparam logic [6:0] SEG_HEX_C = 7'h46;
   localparam logic [6:0] SEG_HEX_D = 7'h21;
   localparam logic [6:0] SEG_HEX_E = 7'h06;
   localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_7seg
   import board_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_code
);

   // Look up the glyph for the nibble; unknown inputs fall back to all off.
   always_comb begin
      seg_code = SEG_OFF;
      case (nibble)
         4'h0:    seg_code = SEG_HEX_0;
         4'h1:    seg_code = SEG_HEX_1;
         4'h2:    seg_code = SEG_HEX_2;
         4'h3:    seg_code = SEG_HEX_3;
         4'h4:    seg_code = SEG_HEX_4;
         4'h5:    seg_code = SEG_HEX_5;
         4'h6:    seg_code = SEG_HEX_6;
         4'h7:    seg_code = SEG_HEX_7;
         4'h8:    seg_code = SEG_HEX_8;
         4'h9:    seg_code = SEG_HEX_9;
         4'hA:    seg_code = SEG_HEX_A;
         4'hB:    seg_code = SEG_HEX_B;
         4'hC:    seg_code = SEG_HEX_C;
         4'hD:    seg_code = SEG_HEX_D;
         4'hE:    seg_code = SEG_HEX_E;
         4'hF:    seg_code = SEG_HEX_F;
         default: seg_code = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment display scanner. Each digit owns a slot of
// REFRESH_DIV cycles; the first BLANK_CYCLES of a slot keep every anode off
// to avoid ghosting. New display data is staged in a pending register and
// only copied into the displayed (shadow) copy at the frame boundary, so a
// frame never mixes old and new content.
module seven_segment_scanner
   import board_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 20000,
   parameter int BLANK_CYCLES = 500
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     digit_en,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      update,
   output logic [NUM_DIGITS-1:0]     an,
   output logic [6:0]                seg,
   output logic                      dp_n,
   output logic                      frame_start
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   // Scan position
   logic [CNT_W-1:0]        cnt_r;
   logic [IDX_W-1:0]        idx_r;
   scan_state_e             state_r;
   logic [CNT_W-1:0]        cnt_next_s;
   logic [IDX_W-1:0]        idx_next_s;
   scan_state_e             state_next_s;
   logic                    slot_wrap_s;
   logic                    frame_wrap_s;

   // Staged and displayed display data
   logic [4*NUM_DIGITS-1:0] pend_value_r;
   logic [NUM_DIGITS-1:0]   pend_en_r;
   logic [NUM_DIGITS-1:0]   pend_dp_r;
   logic                    pend_valid_r;
   logic [4*NUM_DIGITS-1:0] shadow_value_r;
   logic [NUM_DIGITS-1:0]   shadow_en_r;
   logic [NUM_DIGITS-1:0]   shadow_dp_r;

   // Current digit decode
   logic [3:0]              cur_nibble_s;
   logic                    cur_en_s;
   logic                    cur_dp_s;
   logic [6:0]              cur_code_s;

   // Output staging
   logic [NUM_DIGITS-1:0]   an_next_s;
   logic [6:0]              seg_next_s;
   logic                    dp_n_next_s;
   logic                    frame_start_next_s;
   logic [NUM_DIGITS-1:0]   an_r;
   logic [6:0]              seg_r;
   logic                    dp_n_r;
   logic                    frame_start_r;

   // Next scan position: slot counter wraps into the digit index, index wraps into a new frame.
   always_comb begin
      slot_wrap_s  = (cnt_r == CNT_LAST);
      frame_wrap_s = slot_wrap_s && (idx_r == IDX_LAST);

      if (slot_wrap_s) begin
         cnt_next_s = '0;
      end else begin
         cnt_next_s = cnt_r + CNT_W'(1);
      end

      if (frame_wrap_s) begin
         idx_next_s = '0;
      end else if (slot_wrap_s) begin
         idx_next_s = idx_r + IDX_W'(1);
      end else begin
         idx_next_s = idx_r;
      end

      if (cnt_next_s < CNT_BLANK) begin
         state_next_s = ST_BLANK;
      end else begin
         state_next_s = ST_DRIVE;
      end
   end

   // Scan position registers; reset restarts at digit 0, blank phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= '0;
         idx_r   <= '0;
         state_r <= ST_BLANK;
      end else begin
         cnt_r   <= cnt_next_s;
         idx_r   <= idx_next_s;
         state_r <= state_next_s;
      end
   end

   // Pending stage: latest update wins until the frame boundary consumes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_value_r <= '0;
         pend_en_r    <= '0;
         pend_dp_r    <= '0;
         pend_valid_r <= 1'b0;
      end else if (frame_wrap_s) begin
         // Boundary always drains the stage; a coincident update goes straight to shadow.
         pend_valid_r <= 1'b0;
      end else if (update) begin
         pend_value_r <= value;
         pend_en_r    <= digit_en;
         pend_dp_r    <= dp_in;
         pend_valid_r <= 1'b1;
      end
   end

   // Shadow copy changes only at the frame boundary. Reset leaves value/dp zero
   // with all digits enabled so a freshly reset display shows zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_value_r <= '0;
         shadow_en_r    <= '1;
         shadow_dp_r    <= '0;
      end else if (frame_wrap_s && update) begin
         shadow_value_r <= value;
         shadow_en_r    <= digit_en;
         shadow_dp_r    <= dp_in;
      end else if (frame_wrap_s && pend_valid_r) begin
         shadow_value_r <= pend_value_r;
         shadow_en_r    <= pend_en_r;
         shadow_dp_r    <= pend_dp_r;
      end
   end

   // Pick the shadow fields of the digit currently being scanned.
   always_comb begin
      cur_nibble_s = shadow_value_r[4*int'(idx_r) +: 4];
      cur_en_s     = shadow_en_r[idx_r];
      cur_dp_s     = shadow_dp_r[idx_r];
   end

   hex_to_7seg u_hex_to_7seg (
      .nibble   (cur_nibble_s),
      .seg_code (cur_code_s)
   );

   // Output values for the current state; anodes only light an enabled digit in DRIVE.
   always_comb begin
      an_next_s          = '1;
      seg_next_s         = SEG_OFF;
      dp_n_next_s        = 1'b1;
      frame_start_next_s = (state_r == ST_BLANK) && (cnt_r == '0) && (idx_r == '0);

      if ((state_r == ST_DRIVE) && cur_en_s) begin
         an_next_s[idx_r] = 1'b0;
         seg_next_s       = cur_code_s;
         dp_n_next_s      = ~cur_dp_s;
      end else begin
         an_next_s   = '1;
         seg_next_s  = SEG_OFF;
         dp_n_next_s = 1'b1;
      end
   end

   // Registered outputs, forced dark asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_r          <= '1;
         seg_r         <= SEG_OFF;
         dp_n_r        <= 1'b1;
         frame_start_r <= 1'b0;
      end else begin
         an_r          <= an_next_s;
         seg_r         <= seg_next_s;
         dp_n_r        <= dp_n_next_s;
         frame_start_r <= frame_start_next_s;
      end
   end

   assign an          = an_r;
   assign seg         = seg_r;
   assign dp_n        = dp_n_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with 4 digits, 8-cycle slots,
// 2 blank cycles per slot (32-cycle frame).
module tb_seven_segment_scanner;

   logic        clk;
   logic        rst_n;
   logic [15:0] value;
   logic [3:0]  digit_en;
   logic [3:0]  dp_in;
   logic        update;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp_n;
   logic        frame_start;

   int n_cmp = 0;
   int n_bad = 0;
   int pos   = 0;   // frame cycle of the outputs currently visible
   int nwait = 0;

   seven_segment_scanner #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .digit_en    (digit_en),
      .dp_in       (dp_in),
      .update      (update),
      .an          (an),
      .seg         (seg),
      .dp_n        (dp_n),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      pos++;
   endtask

   task automatic go(input int k);
      while (pos < k) tick();
   endtask

   task automatic pulse(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
      value    = v;
      digit_en = e;
      dp_in    = d;
      update   = 1'b1;
      tick();
      update   = 1'b0;
   endtask

   // Advance until frame_start is seen; n returns the number of cycles taken.
   task automatic wait_frame(output int n);
      logic found;
      found = 1'b0;
      n = 0;
      while (!found && n < 100) begin
         @(negedge clk);
         n++;
         if (frame_start === 1'b1) found = 1'b1;
      end
      n_cmp++;
      assert (found) else begin
         n_bad++;
         $error("FAIL frame_wait: observed no frame_start after %0d cycles expected pulse", n);
      end
      pos = 0;
   endtask

   task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
      check({tag, "_an"},  32'(an),   32'(e_an));
      check({tag, "_seg"}, 32'(seg),  32'(e_seg));
      check({tag, "_dp"},  32'(dp_n), 32'(e_dp));
   endtask

   initial begin
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      rst_n    = 1'b0;
      value    = 16'h0000;
      digit_en = 4'h0;
      dp_in    = 4'h0;
      update   = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_out("reset", 4'hF, 7'h7F, 1'b1);
      check("reset_fs", 32'(frame_start), 32'h0);

      // Release: first visible cycle is digit-0 blank with frame_start
      rst_n = 1'b1;
      @(negedge clk);
      pos = 0;
      check("rel_fs0", 32'(frame_start), 32'h1);
      check_out("rel_c0", 4'hF, 7'h7F, 1'b1);
      tick();
      check("rel_fs1", 32'(frame_start), 32'h0);
      check("rel_c1_an", 32'(an), 32'hF);
      tick();
      check_out("rel_c2", 4'hE, 7'h40, 1'b1);
      wait_frame(nwait);
      check("frame_period", 32'(nwait), 32'd30);

      // Mid-frame update is held until the next frame
      go(10);
      pulse(16'h12AF, 4'hF, 4'b0100);
      go(18);
      check_out("old_d2", 4'hB, 7'h40, 1'b1);
      wait_frame(nwait);
      go(2);  check_out("new_d0", 4'hE, 7'h0E, 1'b1);
      go(8);  check_out("new_blank", 4'hF, 7'h7F, 1'b1);
      go(10); check_out("new_d1", 4'hD, 7'h08, 1'b1);
      go(18); check_out("new_d2", 4'hB, 7'h24, 1'b0);
      go(26); check_out("new_d3", 4'h7, 7'h79, 1'b1);

      // Two updates in one frame: only the later one shows
      wait_frame(nwait);
      go(5);  pulse(16'h1111, 4'hF, 4'h0);
      go(20); pulse(16'h2222, 4'hF, 4'h0);
      go(26); check_out("dbl_old_d3", 4'h7, 7'h79, 1'b1);
      wait_frame(nwait);
      go(2);  check_out("dbl_d0", 4'hE, 7'h24, 1'b1);
      go(26); check_out("dbl_d3", 4'h7, 7'h24, 1'b1);

      // Update on the boundary cycle overrides a pending update and drains it
      go(12); pulse(16'h3333, 4'hF, 4'h0);
      go(30); pulse(16'h8888, 4'hF, 4'h0);
      wait_frame(nwait);
      check("bnd_latency", 32'(nwait), 32'd1);
      go(2);  check_out("bnd_d0", 4'hE, 7'h00, 1'b1);
      go(26); check_out("bnd_d3", 4'h7, 7'h00, 1'b1);
      wait_frame(nwait);
      go(2);  check_out("bnd_next_d0", 4'hE, 7'h00, 1'b1);

      // Partial enable: digits 1 and 3 never lit, every slot starts with 2 dark cycles
      go(5); pulse(16'h4567, 4'b0101, 4'h0);
      wait_frame(nwait);
      for (int k = 0; k < 32; k++) begin
         exp_an  = 4'hF;
         exp_seg = 7'h7F;
         if ((k % 8) >= 2 && (k / 8) == 0) begin
            exp_an  = 4'hE;
            exp_seg = 7'h78;
         end else if ((k % 8) >= 2 && (k / 8) == 2) begin
            exp_an  = 4'hB;
            exp_seg = 7'h12;
         end
         check($sformatf("en_an_k%0d", k), 32'(an), 32'(exp_an));
         check($sformatf("en_seg_k%0d", k), 32'(seg), 32'(exp_seg));
         check($sformatf("en_fs_k%0d", k), 32'(frame_start), (k == 0) ? 32'h1 : 32'h0);
         if (k < 31) tick();
      end

      // Reset during digit-2 drive with an update pending
      wait_frame(nwait);
      go(10); pulse(16'h9999, 4'hF, 4'hF);
      go(20); check_out("pre_rst_d2", 4'hB, 7'h12, 1'b1);
      rst_n = 1'b0;
      #1;
      check_out("mid_rst", 4'hF, 7'h7F, 1'b1);
      check("mid_rst_fs", 32'(frame_start), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pos = 0;
      check("rst2_fs", 32'(frame_start), 32'h1);
      go(2);  check_out("rst2_d0", 4'hE, 7'h40, 1'b1);
      wait_frame(nwait);
      check("rst2_period", 32'(nwait), 32'd30);
      go(2);  check_out("rst2_next_d0", 4'hE, 7'h40, 1'b1);
      go(10); check_out("rst2_next_d1", 4'hD, 7'h40, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter NUM_DIGITS, 8, number of multiplexed digits (range 2-8).
REQ-002 Parameter REFRESH_DIV, 20000, clk cycles per digit slot (minimum 4).
REQ-003 Parameter BLANK_CYCLES, 500, cycles at slot start with all anodes off (minimum 1, less than REFRESH_DIV).
REQ-004 clk  input  1  system clock; all state SHALL be on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 value  input  4*NUM_DIGITS  hex nibbles; nibble i SHALL drive digit i.
REQ-007 digit_en  input  NUM_DIGITS  1 = digit shown, 0 = digit blanked.
REQ-008 dp_in  input  NUM_DIGITS  decimal point per digit, active high.
REQ-009 update  input  1  single-cycle strobe; samples value, digit_en and dp_in.
REQ-010 an  output  NUM_DIGITS  digit anodes, active low.
REQ-011 seg  output  7  cathodes {g,f,e,d,c,b,a}, active low.
REQ-012 dp_n  output  1  decimal-point cathode, active low.
REQ-013 frame_start  output  1  one-cycle pulse when digit 0 slot begins.

Function
REQ-014 Slot counter SHALL count 0..REFRESH_DIV-1 and wrap; digit index SHALL advance on wrap, NUM_DIGITS-1 -> 0.
REQ-015 FSM SHALL have states BLANK (counter < BLANK_CYCLES) and DRIVE (remaining cycles), entering BLANK at every slot start.
REQ-016 In BLANK: an all 1s, seg 7'h7F, dp_n 1.
REQ-017 In DRIVE: an has a 0 only at the current index, and only if the shadow digit_en bit is 1; seg/dp_n show the shadow nibble/dp, else all 1s.
REQ-018 All outputs SHALL be registered, one cycle after the state/counter that selects them; no output glitch within a state.
REQ-019 update SHALL load a pending register and set pending_valid; a later update before the frame boundary overwrites it.
REQ-020 At index wrap to 0 (frame boundary) the shadow SHALL load pending if pending_valid, clearing pending_valid; the displayed frame never mixes old and new data.
REQ-021 update coinciding with the frame boundary: shadow SHALL take the incoming inputs directly; pending_valid SHALL end cleared.
REQ-022 frame_start SHALL pulse in the same cycle the outputs first reflect the digit-0 BLANK state.
REQ-023 Hex encoding (gfedcba, active low): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E.

Reset
REQ-024 rst_n low SHALL immediately force an all 1s, seg 7'h7F, dp_n 1, frame_start 0.
REQ-025 Reset SHALL clear counter, digit index, shadow, pending and pending_valid; on release the first cycle is digit 0 BLANK with frame_start pulsed.
REQ-026 Reset asserted mid-slot or mid-frame SHALL discard pending data; no partial digit is resumed.

Structure
REQ-027 Package board_pkg SHALL hold the segment-code constants, SEG_OFF (7'h7F) and the FSM state enum.
REQ-028 One sub-module, hex_to_7seg (4-bit nibble in, 7-bit active-low code out, combinational), SHALL perform REQ-023.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-029 Reset release -> an=4'b1111 two cycles, then an=4'b1110, seg reflects shadow 0 = 7'h40, frame_start pulses once per 32 cycles.
REQ-030 update with value=16'h12AF, digit_en=4'hF, dp_in=4'b0100 mid-frame -> old data until next frame_start, then seg 0F?: digit0=0E, digit1=08, digit2=24 with dp_n 0, digit3=79.
REQ-031 Two updates (16'h1111 then 16'h2222) in one frame -> next frame shows only 2222 (seg 7'h24).
REQ-032 update on the frame-boundary cycle with 16'h8888 -> that frame shows 7'h00; pending_valid 0 afterward.
REQ-033 digit_en=4'b0101 -> an never drives digits 1,3 low; every slot starts with 2 all-off cycles.
REQ-034 rst_n low in digit-2 DRIVE -> outputs off same cycle; after release, scan restarts at digit 0 with shadow 0.
